// File: rtl/memory_unit.sv
// memory_unit: single-word 35-bit holding register, organised as five 7-bit lanes.
// Loads din on a rising clk edge when wren is high, otherwise holds.
// Synchronous active-high reset (arst) has priority over wren.
// dout is driven straight from the lane flops, so there is no combinational path to it.
module memory_unit #(
    parameter int unsigned LANE_W = 7,
    parameter int unsigned LANES  = 5
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      wren,
    input  logic [LANE_W*LANES-1:0]   din,
    output logic [LANE_W*LANES-1:0]   dout
);

    // Each lane is an independent register sharing clk, arst and wren.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LANE_W-1:0] lane_q;

        // Lane storage: reset clears, write loads the lane slice of din, else hold.
        always_ff @(posedge clk) begin
            if (arst) begin
                lane_q <= '0;
            end else if (wren) begin
                lane_q <= din[k*LANE_W +: LANE_W];
            end
        end

        assign dout[k*LANE_W +: LANE_W] = lane_q;
    end

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed self-checking bench for memory_unit.
// Inputs change and outputs are sampled on the falling clk edge.
module tb_memory_unit;

    localparam int unsigned LANE_W = 7;
    localparam int unsigned LANES  = 5;
    localparam int unsigned W      = LANE_W * LANES;

    logic         clk;
    logic         arst;
    logic         wren;
    logic [W-1:0] din;
    logic [W-1:0] dout;

    int checks;
    int failures;

    memory_unit #(
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_dut (
        .clk  (clk),
        .arst (arst),
        .wren (wren),
        .din  (din),
        .dout (dout)
    );

    // 50 ns period with rising edges at 50, 100, 150 ns, ...
    initial begin
        clk = 1'b1;
        forever #25 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [W-1:0] obs,
                            input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 35'h%09h expected 35'h%09h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] exp_val;
        checks   = 0;
        failures = 0;

        // Reset for two edges
        arst = 1'b1;
        wren = 1'b0;
        din  = '0;
        tick();
        check_eq("reset_edge1", dout, 35'h0);
        tick();
        check_eq("reset_edge2", dout, 35'h0);

        // Write pattern
        arst = 1'b0;
        wren = 1'b1;
        din  = 35'h0_0FE0_3F80;
        #1;
        check_eq("no_comb_path_before_edge", dout, 35'h0);
        tick();
        check_eq("write_pattern", dout, 35'h0_0FE0_3F80);

        // Hold for 6 edges with din changed
        wren = 1'b0;
        din  = 35'h0_0000_3F80;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("hold_%0d", i), dout, 35'h0_0FE0_3F80);
        end

        // Rewrite, then all ones
        wren = 1'b1;
        din  = 35'h0_0000_3F80;
        tick();
        check_eq("rewrite_3f80", dout, 35'h0_0000_3F80);
        din = 35'h7_FFFF_FFFF;
        tick();
        check_eq("rewrite_all_ones", dout, 35'h7_FFFF_FFFF);

        // Reset priority over write
        arst = 1'b1;
        wren = 1'b1;
        din  = 35'h7_FFFF_FFFF;
        tick();
        check_eq("reset_priority", dout, 35'h0);

        // Walking 0x7F through each lane
        arst = 1'b0;
        for (int k = 0; k < int'(LANES); k++) begin
            exp_val = 35'h7F << (LANE_W * k);
            din     = exp_val;
            tick();
            check_eq($sformatf("lane_walk_%0d", k), dout, exp_val);
        end

        // din change between edges must not reach dout
        din = 35'h5_5555_5555;
        #1;
        check_eq("no_glitch_mid_cycle", dout, 35'h7_F000_0000);

        // Consecutive writes: dout follows din one edge later
        din = 35'h5_5555_5555;
        tick();
        check_eq("consec_1", dout, 35'h5_5555_5555);
        din = 35'h2_AAAA_AAAA;
        tick();
        check_eq("consec_2", dout, 35'h2_AAAA_AAAA);

        // Mid-operation reset clears, and holds while asserted
        wren = 1'b0;
        arst = 1'b1;
        #1;
        check_eq("reset_not_async", dout, 35'h2_AAAA_AAAA);
        tick();
        check_eq("mid_reset", dout, 35'h0);
        tick();
        check_eq("mid_reset_held", dout, 35'h0);

        // Hold after reset with wren low
        arst = 1'b0;
        din  = 35'h1_2345_6789;
        tick();
        check_eq("hold_after_reset", dout, 35'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
